// File: rtl/memory_access.sv
// rtl/memory_access.sv - Y86-64 memory stage: byte-serial quad-word load/store with bounds check and timeout
module memory_access #(
   parameter int MEM_BYTES = 1024,
   parameter int TIMEOUT   = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [3:0]  icode_i,
   input  logic [63:0] valE_i,
   input  logic [63:0] valA_i,
   input  logic [63:0] valP_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [63:0] valM_o,
   output logic [2:0]  stat_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [63:0] mem_addr_o,
   output logic [7:0]  mem_wdata_o,
   input  logic [7:0]  mem_rdata_i,
   input  logic        mem_ack_i
);

   localparam logic [2:0]  STAT_AOK = 3'd1;
   localparam logic [2:0]  STAT_HLT = 3'd2;
   localparam logic [2:0]  STAT_ADR = 3'd3;
   localparam logic [2:0]  STAT_INS = 3'd4;
   localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);
   localparam int          TW       = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t        state, state_nx;
   logic          is_write;
   logic [63:0]   addr;
   logic [63:0]   data;
   logic [2:0]    k;
   logic [TW-1:0] tcnt;

   logic          dec_acc, dec_wr, oob, accept, xfer, ack_hit, timeout_hit;
   logic [63:0]   dec_addr, dec_data;
   logic [2:0]    dec_stat;

   always_comb begin
      dec_acc  = 1'b0;
      dec_wr   = 1'b0;
      dec_addr = valE_i;
      dec_data = valA_i;
      dec_stat = STAT_AOK;
      case (icode_i)
         4'h4: begin dec_acc = 1'b1; dec_wr = 1'b1; end
         4'h5: dec_acc = 1'b1;
         4'h8: begin dec_acc = 1'b1; dec_wr = 1'b1; dec_data = valP_i; end
         4'h9: begin dec_acc = 1'b1; dec_addr = valA_i; end
         4'hA: begin dec_acc = 1'b1; dec_wr = 1'b1; end
         4'hB: begin dec_acc = 1'b1; dec_addr = valA_i; end
         4'h1: dec_stat = STAT_HLT;
         4'hC, 4'hD, 4'hE, 4'hF: dec_stat = STAT_INS;
         default: dec_stat = STAT_AOK;
      endcase
   end

   // Unsigned compare also rejects addresses whose 8-byte span would wrap past 2^64
   assign oob         = dec_addr > ADDR_MAX;
   assign xfer        = (state == XFER);
   assign accept      = start_i && !xfer;
   assign ack_hit     = xfer && mem_ack_i;
   assign timeout_hit = xfer && !mem_ack_i && (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: begin
            if (start_i)             state_nx = (dec_acc && !oob) ? XFER : DONE;
            else if (state == DONE)  state_nx = IDLE;
         end
         XFER: begin
            if ((ack_hit && k == 3'd7) || timeout_hit) state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         is_write <= 1'b0;
         addr     <= '0;
         data     <= '0;
         k        <= '0;
         tcnt     <= '0;
         valM_o   <= '0;
         stat_o   <= STAT_AOK;
      end else if (accept) begin
         is_write <= dec_wr;
         addr     <= dec_addr;
         data     <= dec_data;
         k        <= '0;
         tcnt     <= '0;
         valM_o   <= '0;
         stat_o   <= dec_acc ? (oob ? STAT_ADR : STAT_AOK) : dec_stat;
      end else if (xfer) begin
         if (mem_ack_i) begin
            if (!is_write) valM_o[{k, 3'b000} +: 8] <= mem_rdata_i;
            k    <= k + 3'd1;
            tcnt <= '0;
         end else if (timeout_hit) begin
            valM_o <= '0;
            stat_o <= STAT_ADR;
            k      <= '0;
            tcnt   <= '0;
         end else begin
            tcnt <= tcnt + TW'(1);
         end
      end
   end

   // Bus outputs decode straight from the state register so reset drops them asynchronously
   assign busy_o      = xfer;
   assign done_o      = (state == DONE);
   assign mem_req_o   = xfer;
   assign mem_we_o    = xfer && is_write;
   assign mem_addr_o  = xfer ? (addr + {61'b0, k}) : '0;
   assign mem_wdata_o = (xfer && is_write) ? data[{k, 3'b000} +: 8] : '0;

endmodule

// File: doc/memory_access.md
# memory_access

Y86-64 memory stage of the sequential CPU. It sits directly downstream of `execute` and consumes its `valE_o` result together with the decoded `icode`, `valA` and `valP`. It performs the 64-bit little-endian load or store implied by the instruction over a byte-serial req/ack data-memory bus. It returns `valM` and a Y86 status code to writeback.

## Interface
- `MEM_BYTES`, default 1024: size of the data memory in bytes. The legal quad-word address range is 0..MEM_BYTES-8.
- `TIMEOUT`, default 16: number of cycles a single byte request may wait for `mem_ack_i` before the access is aborted.
- `clk_i`  in  1: clock, rising edge.
- `rst_n_i`  in  1: reset, asynchronous and active-low.
- `start_i`  in  1: begin the memory stage for the presented instruction. Sampled only when `busy_o`=0.
- `icode_i`  in  4: instruction code.
- `valE_i`  in  64: execute result.
- `valA_i`  in  64: register A value.
- `valP_i`  in  64: next PC.
- `busy_o`  out  1: high in XFER.
- `done_o`  out  1: one-cycle completion pulse.
- `valM_o`  out  64: loaded quad word. 0 for non-loads and for any error.
- `stat_o`  out  3: status code. 1=AOK, 2=HLT, 3=ADR, 4=INS.
- `mem_req_o`  out  1: byte request.
- `mem_we_o`  out  1: 1=write, 0=read.
- `mem_addr_o`  out  64: byte address.
- `mem_wdata_o`  out  8: write byte.
- `mem_rdata_i`  in  8: read byte. Valid when `mem_ack_i`=1.
- `mem_ack_i`  in  1: byte complete. Only meaningful while `mem_req_o`=1.

## Operation
- States: IDLE, XFER, DONE.
- Reset values: state=IDLE, `busy_o`=0, `done_o`=0, `valM_o`=0, `stat_o`=1, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0. Internal byte index and timeout counter are 0.
- On `start_i`=1 in IDLE or DONE, latch all inputs and clear `valM_o`. Access type is selected by icode:
  - 4 (rmmov): write, addr=valE, data=valA.
  - 5 (mrmov): read, addr=valE.
  - 8 (call): write, addr=valE, data=valP.
  - 9 (ret): read, addr=valA.
  - A (push): write, addr=valE, data=valA.
  - B (pop): read, addr=valA.
  - 0, 2, 3, 6, 7: no access, stat=AOK.
  - 1 (halt): no access, stat=HLT.
  - C..F: no access, stat=INS.
- No-access instructions go directly to DONE.
- Bounds check, done at start: addr > MEM_BYTES-8, as a 64-bit unsigned compare, means no bus activity, stat=ADR, go to DONE. Addresses that would wrap past 2^64 are also caught by this check.
- XFER, byte k from 0 to 7:
  - `mem_req_o`=1, `mem_addr_o`=addr+k, `mem_we_o` set per the access type.
  - `mem_wdata_o` = data[8k+7:8k].
  - All of these are held stable until `mem_ack_i` is sampled high.
  - On ack during a read, capture `mem_rdata_i` into `valM_o[8k+7:8k]`.
  - On ack, advance k and clear the timeout counter. `mem_req_o` stays high between bytes.
  - After the ack for k=7: `mem_req_o`=0, stat=AOK, go to DONE.
- Timeout: the counter increments on each cycle with req=1 and ack=0. When it reaches TIMEOUT:
  - `mem_req_o` drops.
  - `valM_o` is set to 0 and stat=ADR.
  - The state goes to DONE.
- DONE: `done_o`=1 for exactly one cycle, then IDLE unless `start_i`=1, in which case the next instruction is accepted. `valM_o` and `stat_o` hold until the next accepted start.
- `start_i` during XFER is ignored; the instruction is not queued.
- Reset asserted mid-transfer: all outputs return to their reset values immediately, asynchronously, and `mem_req_o` drops in the same instant. No partial result is kept.

## Timing
- Start is sampled at edge E0.
- No-access or bounds error: `done_o` is high in the cycle after E0, so latency is 1.
- Access with ack tied high: `mem_req_o` is high for cycles 1..8 and `done_o` is high in cycle 9, so latency is 9.
- Each wait cycle on a byte adds 1 cycle of latency.
- Timeout: the abort occurs at the TIMEOUT-th consecutive unacked cycle of a byte. `done_o` is high in the following cycle.
- Writes complete byte-by-byte, so a timeout mid-write leaves earlier bytes committed in memory.
- Back-to-back operation: `start_i`=1 while `done_o`=1 starts the new instruction with no idle cycle.

## Test plan
- mrmov, valE=0x100, memory bytes 0x100..0x107 = 01..08, ack tied high -> 8 read requests at 0x100..0x107; `valM_o`=0x0807060504030201, stat=1, `done_o` in cycle 9.
- push, valE=0x3F8, valA=0x0123456789ABCDEF, ack with 2 wait cycles per byte -> write bytes EF,CD,AB,89,67,45,23,01 at 0x3F8..0x3FF; `done_o` in cycle 25; stat=1.
- rmmov, valE=0x3F9 (MEM_BYTES=1024) -> no `mem_req_o`, stat=3, `valM_o`=0, `done_o` in cycle 1. Repeat with valE=0xFFFFFFFFFFFFFFFC -> also stat=3.
- ret, valA=0x40, ack withheld from byte 3 onward -> bytes 0..2 captured, abort after 16 unacked cycles, then `valM_o`=0, stat=3, `mem_req_o`=0.
- halt, then icode=0xD, then opq (icode 6), issued back-to-back with start held high -> three `done_o` pulses on consecutive cycles with stat=2, 4, 1; no bus activity.
- pop mid-transfer: assert `rst_n_i`=0 at byte 4 -> `mem_req_o`, `busy_o` and `valM_o` go to 0 immediately; after release, a new mrmov completes normally.
